fetch_controller: RTL and testbench

- Sequences instruction fetch for the single-cycle RISC-V core.
- Replaces the free-running PC-plus-4 update with a controlled PC that waits on a request/ready instruction-memory handshake and holds a fetched instruction until decode accepts it.
- Redirects to a new PC on branch/jump.
- Sits between the PC register position in Processor and the InstructionMemory, and feeds decode.

---
 rtl/fetch_controller.sv | 130 +++++++++++++
 tb/tb_fetch_controller.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: drives a req/ready instruction-memory handshake,
// holds each fetched word until decode accepts it, and follows branch/jump redirects.
module fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic        misalign_err,
  output logic [31:0] instr_count
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_VALID,
    S_DISCARD,
    S_HALT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_addr_q, hold_addr_d;
  logic [31:0] instr_out_q, instr_out_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic [31:0] count_q, count_d;
  logic        misalign_q, misalign_d;
  logic        bad_target;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    hold_addr_d = hold_addr_q;
    instr_out_d = instr_out_q;
    instr_pc_d  = instr_pc_q;
    count_d     = count_q;
    misalign_d  = misalign_q;
    bad_target  = redirect_valid && (redirect_pc[1:0] != 2'b00);

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        if (bad_target) begin
          state_d    = S_HALT;
          misalign_d = 1'b1;
        end else if (redirect_valid) begin
          // The in-flight address is kept on the bus until memory answers it.
          pc_d        = redirect_pc;
          hold_addr_d = pc_q;
          state_d     = imem_ready ? S_FETCH : S_DISCARD;
        end else if (imem_ready) begin
          instr_out_d = imem_rdata;
          instr_pc_d  = pc_q;
          state_d     = S_VALID;
        end
      end

      S_VALID: begin
        if (bad_target) begin
          state_d    = S_HALT;
          misalign_d = 1'b1;
        end else if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = S_FETCH;
          if (instr_ready) count_d = count_q + 32'd1;
        end else if (instr_ready) begin
          pc_d    = pc_q + STEP;
          count_d = count_q + 32'd1;
          state_d = S_FETCH;
        end
      end

      S_DISCARD: begin
        if (bad_target) begin
          state_d    = S_HALT;
          misalign_d = 1'b1;
        end else begin
          if (redirect_valid) pc_d = redirect_pc;
          if (imem_ready) state_d = S_FETCH;
        end
      end

      S_HALT: state_d = S_HALT;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      hold_addr_q <= 32'h0;
      instr_out_q <= 32'h0;
      instr_pc_q  <= 32'h0;
      count_q     <= 32'h0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      hold_addr_q <= hold_addr_d;
      instr_out_q <= instr_out_d;
      instr_pc_q  <= instr_pc_d;
      count_q     <= count_d;
      misalign_q  <= misalign_d;
    end
  end

  assign imem_req     = (state_q == S_FETCH) || (state_q == S_DISCARD);
  assign imem_addr    = (state_q == S_DISCARD) ? hold_addr_q : pc_q;
  assign instr_valid  = (state_q == S_VALID);
  assign instr_out    = instr_out_q;
  assign instr_pc     = instr_pc_q;
  assign misalign_err = misalign_q;
  assign instr_count  = count_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: a cycle-by-cycle vector table plus
// hand-written sequences for start-up latency and throughput.
module tb_fetch_controller;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        misalign_err;
  logic [31:0] instr_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Memory returns a tagged copy of the address so captured data is traceable.
  assign imem_rdata = imem_addr ^ KEY;

  fetch_controller #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_out      (instr_out),
    .instr_pc       (instr_pc),
    .misalign_err   (misalign_err),
    .instr_count    (instr_count)
  );

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        ir;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_ipc;
    logic        e_mis;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t v(input logic rst, input logic rdy, input logic rv,
                             input logic [31:0] rpc, input logic ir,
                             input logic e_req, input logic [31:0] e_addr,
                             input logic e_iv, input logic [31:0] e_ipc,
                             input logic e_mis, input logic [31:0] e_cnt);
    vec_t r;
    r.rst = rst; r.rdy = rdy; r.rv = rv; r.rpc = rpc; r.ir = ir;
    r.e_req = e_req; r.e_addr = e_addr; r.e_iv = e_iv; r.e_ipc = e_ipc;
    r.e_mis = e_mis; r.e_cnt = e_cnt;
    return r;
  endfunction

  task automatic chk(input string name, input int step, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
    end
  endtask

  initial begin
    int n;

    reset = 1'b1; imem_ready = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'h0; instr_ready = 1'b0;

    //          rst rdy rv rpc           ir   req addr          iv ipc           mis cnt
    // Zero-wait streaming: fetch 0, 4
    vq.push_back(v(1, 1, 0, 32'h0,        1,   0, 32'h0,        0, 32'h0,        0, 0));
    vq.push_back(v(0, 1, 0, 32'h0,        1,   1, 32'h0,        0, 32'h0,        0, 0));
    vq.push_back(v(0, 1, 0, 32'h0,        1,   0, 32'h0,        1, 32'h0,        0, 0));
    vq.push_back(v(0, 1, 0, 32'h0,        1,   1, 32'h4,        0, 32'h0,        0, 1));
    vq.push_back(v(0, 1, 0, 32'h0,        1,   0, 32'h0,        1, 32'h4,        0, 1));
    vq.push_back(v(0, 1, 0, 32'h0,        1,   1, 32'h8,        0, 32'h0,        0, 2));
    // Memory stalls 5 cycles on 0x8
    for (int i = 0; i < 5; i++)
      vq.push_back(v(0, 0, 0, 32'h0,      1,   1, 32'h8,        0, 32'h0,        0, 2));
    vq.push_back(v(0, 1, 0, 32'h0,        0,   0, 32'h0,        1, 32'h8,        0, 2));
    // Decode stalls 3 cycles
    for (int i = 0; i < 3; i++)
      vq.push_back(v(0, 1, 0, 32'h0,      0,   0, 32'h0,        1, 32'h8,        0, 2));
    vq.push_back(v(0, 1, 0, 32'h0,        1,   1, 32'hC,        0, 32'h0,        0, 3));
    vq.push_back(v(0, 1, 0, 32'h0,        1,   0, 32'h0,        1, 32'hC,        0, 3));
    vq.push_back(v(0, 1, 0, 32'h0,        1,   1, 32'h10,       0, 32'h0,        0, 4));
    // Redirect to 0x100 while 0x10 is outstanding
    vq.push_back(v(0, 0, 0, 32'h0,        1,   1, 32'h10,       0, 32'h0,        0, 4));
    vq.push_back(v(0, 0, 1, 32'h100,      1,   1, 32'h10,       0, 32'h0,        0, 4));
    vq.push_back(v(0, 0, 0, 32'h0,        1,   1, 32'h10,       0, 32'h0,        0, 4));
    vq.push_back(v(0, 1, 0, 32'h0,        1,   1, 32'h100,      0, 32'h0,        0, 4));
    vq.push_back(v(0, 1, 0, 32'h0,        0,   0, 32'h0,        1, 32'h100,      0, 4));
    // Redirect coinciding with accept: counts, pc takes target
    vq.push_back(v(0, 1, 1, 32'h20,       1,   1, 32'h20,       0, 32'h0,        0, 5));
    vq.push_back(v(0, 1, 0, 32'h0,        0,   0, 32'h0,        1, 32'h20,       0, 5));
    vq.push_back(v(0, 1, 1, 32'h40,       1,   1, 32'h40,       0, 32'h0,        0, 6));
    vq.push_back(v(0, 1, 0, 32'h0,        0,   0, 32'h0,        1, 32'h40,       0, 6));
    // Redirect while memory answers: data dropped, refetch at target
    vq.push_back(v(0, 1, 0, 32'h0,        1,   1, 32'h44,       0, 32'h0,        0, 7));
    vq.push_back(v(0, 1, 1, 32'h80,       0,   1, 32'h80,       0, 32'h0,        0, 7));
    vq.push_back(v(0, 1, 0, 32'h0,        0,   0, 32'h0,        1, 32'h80,       0, 7));
    // Two redirects in DISCARD: the latest wins
    vq.push_back(v(0, 1, 0, 32'h0,        1,   1, 32'h84,       0, 32'h0,        0, 8));
    vq.push_back(v(0, 0, 1, 32'h200,      0,   1, 32'h84,       0, 32'h0,        0, 8));
    vq.push_back(v(0, 0, 1, 32'h300,      0,   1, 32'h84,       0, 32'h0,        0, 8));
    vq.push_back(v(0, 1, 0, 32'h0,        0,   1, 32'h300,      0, 32'h0,        0, 8));
    vq.push_back(v(0, 1, 0, 32'h0,        0,   0, 32'h0,        1, 32'h300,      0, 8));
    // Misaligned target halts until reset
    vq.push_back(v(0, 1, 1, 32'h102,      0,   0, 32'h0,        0, 32'h0,        1, 8));
    vq.push_back(v(0, 1, 0, 32'h0,        1,   0, 32'h0,        0, 32'h0,        1, 8));
    vq.push_back(v(0, 1, 0, 32'h0,        1,   0, 32'h0,        0, 32'h0,        1, 8));
    vq.push_back(v(0, 1, 1, 32'h200,      1,   0, 32'h0,        0, 32'h0,        1, 8));
    vq.push_back(v(1, 1, 0, 32'h0,        0,   0, 32'h0,        0, 32'h0,        0, 0));
    vq.push_back(v(0, 1, 0, 32'h0,        0,   1, 32'h0,        0, 32'h0,        0, 0));
    // Redirect (even misaligned) is ignored in IDLE
    vq.push_back(v(1, 1, 0, 32'h0,        0,   0, 32'h0,        0, 32'h0,        0, 0));
    vq.push_back(v(0, 0, 1, 32'h502,      0,   1, 32'h0,        0, 32'h0,        0, 0));
    // Reset mid-DISCARD
    vq.push_back(v(0, 0, 1, 32'h600,      0,   1, 32'h0,        0, 32'h0,        0, 0));
    vq.push_back(v(1, 0, 0, 32'h0,        0,   0, 32'h0,        0, 32'h0,        0, 0));
    // Reset mid-VALID with a non-zero count
    vq.push_back(v(0, 1, 0, 32'h0,        0,   1, 32'h0,        0, 32'h0,        0, 0));
    vq.push_back(v(0, 1, 0, 32'h0,        0,   0, 32'h0,        1, 32'h0,        0, 0));
    vq.push_back(v(0, 1, 0, 32'h0,        1,   1, 32'h4,        0, 32'h0,        0, 1));
    vq.push_back(v(0, 1, 0, 32'h0,        0,   0, 32'h0,        1, 32'h4,        0, 1));
    vq.push_back(v(1, 1, 0, 32'h0,        1,   0, 32'h0,        0, 32'h0,        0, 0));
    // PC wrap from 0xFFFF_FFFC
    vq.push_back(v(0, 1, 0, 32'h0,        0,   1, 32'h0,        0, 32'h0,        0, 0));
    vq.push_back(v(0, 1, 0, 32'h0,        0,   0, 32'h0,        1, 32'h0,        0, 0));
    vq.push_back(v(0, 1, 1, 32'hFFFF_FFFC,1,   1, 32'hFFFF_FFFC,0, 32'h0,        0, 1));
    vq.push_back(v(0, 1, 0, 32'h0,        0,   0, 32'h0,        1, 32'hFFFF_FFFC,0, 1));
    vq.push_back(v(0, 1, 0, 32'h0,        1,   1, 32'h0,        0, 32'h0,        0, 2));

    for (int i = 0; i < vq.size(); i++) begin
      reset          = vq[i].rst;
      imem_ready     = vq[i].rdy;
      redirect_valid = vq[i].rv;
      redirect_pc    = vq[i].rpc;
      instr_ready    = vq[i].ir;
      @(posedge clk);
      #1;
      chk("imem_req", i, {31'b0, imem_req}, {31'b0, vq[i].e_req});
      chk("instr_valid", i, {31'b0, instr_valid}, {31'b0, vq[i].e_iv});
      chk("misalign_err", i, {31'b0, misalign_err}, {31'b0, vq[i].e_mis});
      chk("instr_count", i, instr_count, vq[i].e_cnt);
      if (vq[i].e_req) chk("imem_addr", i, imem_addr, vq[i].e_addr);
      if (vq[i].e_iv) begin
        chk("instr_pc", i, instr_pc, vq[i].e_ipc);
        chk("instr_out", i, instr_out, vq[i].e_ipc ^ KEY);
      end
      $display("step %0d: req=%b addr=%h valid=%b pc=%h out=%h mis=%b cnt=%0d",
               i, imem_req, imem_addr, instr_valid, instr_pc, instr_out,
               misalign_err, instr_count);
    end

    // Start-up latency with zero-wait memory: IDLE, FETCH, then VALID in the third cycle.
    reset = 1'b1; imem_ready = 1'b1; instr_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    n = 0;
    while (n < 10) begin
      @(posedge clk);
      #1;
      n++;
      if (instr_valid) break;
    end
    chk("first_valid_edges", 0, 32'(n), 32'd2);
    $display("startup: instr_valid seen after %0d edges", n);

    // Never-stalling decode: one instruction per two cycles.
    repeat (8) @(posedge clk);
    #1;
    chk("throughput_count", 0, instr_count, 32'd4);
    $display("throughput: count=%0d after 8 cycles", instr_count);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
